// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals for imem_loader.
// The loader uses the slave modport; the host or byte receiver uses the master modport.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = 15
);
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              busy;
   logic              done;
   logic              error;
   logic              cpu_hold;

   modport master (
      output start, rx_data, rx_valid,
      input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
   );

   modport slave (
      input  start, rx_data, rx_valid,
      output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into words written to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
   parameter int unsigned ADDR_W = 15
) (
   input logic          i_clk,
   input logic          i_rst,
   imem_loader_if.slave bus
);
   typedef enum logic [2:0] {StIdle, StLen, StData, StWrite, StChk, StDone} state_e;

   localparam logic [32:0] MaxWords = 33'd1 << ADDR_W;

   state_e            r_state, w_state_nxt;
   logic [1:0]        r_byte_cnt;
   logic [23:0]       r_shift;
   logic [ADDR_W:0]   r_count;
   logic [ADDR_W:0]   r_index;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic              r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        r_chk;
`endif

   logic              w_rx_ready;
   logic              w_xfer;
   logic              w_field_done;
   logic              w_start_ok;
   logic              w_too_long;
   logic [31:0]       w_word;
   logic [ADDR_W:0]   w_index_inc;

   assign w_rx_ready   = (r_state == StLen) || (r_state == StData) || (r_state == StChk);
   assign w_xfer       = bus.rx_valid && w_rx_ready;
   assign w_field_done = w_xfer && (r_byte_cnt == 2'd3);
   assign w_start_ok   = bus.start && ((r_state == StIdle) || (r_state == StDone));
   // New byte enters at the top so the first byte of a field ends up in [7:0].
   assign w_word       = {bus.rx_data, r_shift};
   assign w_too_long   = {1'b0, w_word} > MaxWords;
   assign w_index_inc  = r_index + (ADDR_W+1)'(1);

   assign bus.rx_ready  = w_rx_ready;
   assign bus.mem_we    = (r_state == StWrite);
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.busy      = (r_state == StLen) || (r_state == StData) ||
                          (r_state == StWrite) || (r_state == StChk);
   assign bus.done      = (r_state == StDone);
   assign bus.error     = r_error;
   assign bus.cpu_hold  = !((r_state == StDone) && !r_error);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (bus.start) w_state_nxt = StLen;
         StLen: begin
            if (w_field_done) begin
               if ((w_word == 32'd0) || w_too_long) w_state_nxt = StDone;
               else                                 w_state_nxt = StData;
            end
         end
         StData:  if (w_field_done) w_state_nxt = StWrite;
         StWrite: begin
            if (w_index_inc == r_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_state_nxt = StChk;
`else
               w_state_nxt = StDone;
`endif
            end else begin
               w_state_nxt = StData;
            end
         end
         StChk:   if (w_xfer) w_state_nxt = StDone;
         StDone:  if (bus.start) w_state_nxt = StLen;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_byte_cnt  <= 2'd0;
         r_shift     <= 24'd0;
         r_count     <= '0;
         r_index     <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_chk       <= 8'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (w_start_ok) begin
            r_byte_cnt <= 2'd0;
            r_index    <= '0;
            r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk      <= 8'd0;
`endif
         end
         if (w_xfer && ((r_state == StLen) || (r_state == StData))) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= w_word[31:8];
         end
         if ((r_state == StLen) && w_field_done) begin
            r_count <= w_word[ADDR_W:0];
            if (w_too_long) r_error <= 1'b1;
         end
         if ((r_state == StData) && w_field_done) begin
            r_mem_addr  <= r_index[ADDR_W-1:0];
            r_mem_wdata <= w_word;
         end
         if (r_state == StWrite) r_index <= w_index_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
         if ((r_state == StData) && w_xfer) r_chk <= r_chk ^ bus.rx_data;
         if ((r_state == StChk) && w_xfer && (bus.rx_data != r_chk)) r_error <= 1'b1;
`endif
      end
   end
endmodule
